sid_write_scheduler: RTL and testbench

- Owns the single SID register write port (strobe, 5-bit addr, 8-bit data) and shares it between three requesters: the host data bus (phi2-decoded writes), a host command stream (SPI/USB decoder), and an internal register-clear sequencer.
- Paces all writes to the 1 MHz SID clock enable, at most one write per enable tick.
- Sits between the bus/command front-ends and the sid core in the top level.

---
 rtl/sid_bus_pkg.sv | 29 ++
 rtl/sid_write_scheduler_if.sv | 34 +++
 rtl/sid_wr_fifo.sv | 67 ++++++
 rtl/sid_write_scheduler.sv | 138 +++++++++++++
 tb/tb_sid_write_scheduler.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sid_bus_pkg.sv
// Shared SID write-port types: register geometry, write-source codes, clear FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sid_bus_pkg;

  localparam int SID_ADDR_W   = 5;
  localparam int SID_DATA_W   = 8;
  localparam int SID_NUM_REGS = 25;

  // Who owns the current sid_wr strobe
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_BUS   = 2'd1,
    SRC_CLEAR = 2'd2,
    SRC_CMD   = 2'd3
  } sid_src_e;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

  // One queued register write, {addr,data} = 13 bits
  typedef struct packed {
    logic [SID_ADDR_W-1:0] addr;
    logic [SID_DATA_W-1:0] data;
  } sid_wr_t;

endpackage

// File: rtl/sid_write_scheduler_if.sv
// Request/response bundle between the bus/command front-ends and the SID write scheduler.
// Latency: n/a (wiring only).
// Backpressure: cmd side is valid/ready; bus side cannot be stalled.
interface sid_write_scheduler_if;
  import sid_bus_pkg::*;

  logic                  bus_valid;
  logic [SID_ADDR_W-1:0] bus_addr;
  logic [SID_DATA_W-1:0] bus_data;
  logic                  bus_overrun;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [SID_ADDR_W-1:0] cmd_addr;
  logic [SID_DATA_W-1:0] cmd_data;

  logic                  sid_wr;
  logic [SID_ADDR_W-1:0] sid_addr;
  logic [SID_DATA_W-1:0] sid_data;
  logic [1:0]            sid_wr_src;

  // Requester side: drives writes, observes the SID port
  modport master (
    output bus_valid, bus_addr, bus_data, cmd_valid, cmd_addr, cmd_data,
    input  bus_overrun, cmd_ready, sid_wr, sid_addr, sid_data, sid_wr_src
  );

  // Scheduler side
  modport slave (
    input  bus_valid, bus_addr, bus_data, cmd_valid, cmd_addr, cmd_data,
    output bus_overrun, cmd_ready, sid_wr, sid_addr, sid_data, sid_wr_src
  );

endinterface

// File: rtl/sid_wr_fifo.sv
// Synchronous FIFO of {addr,data} SID writes, count-based full/empty.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: in_rdy is registered !full (low in reset); pop while full frees a slot next cycle.
module sid_wr_fifo
  import sid_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    sys_clk,
  input  logic    rst_n,
  input  logic    in_vld,
  output logic    in_rdy,
  input  sid_wr_t in_dat,
  output logic    out_vld,
  input  logic    out_rdy,
  output sid_wr_t out_dat
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sid_wr_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic               rdy_q;
  logic               push;
  logic               pop;

  assign push    = in_vld & rdy_q;
  assign pop     = out_vld & out_rdy;
  assign in_rdy  = rdy_q;
  assign out_vld = (count != '0);
  assign out_dat = mem[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and registered ready
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      rdy_q <= (count_nxt != CNT_W'(DEPTH));
    end
  end

  // Storage needs no reset; occupancy gates what is visible
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

endmodule

// File: rtl/sid_write_scheduler.sv
// Shares the SID register write port between bus slot, clear sweep and command FIFO.
// Latency: one write per clk_en tick, strobe registered one cycle after the winning tick.
// Backpressure: bus cannot stall (overwrite + overrun pulse); cmd uses valid/ready FIFO.
module sid_write_scheduler
  import sid_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_REGS   = SID_NUM_REGS
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  input  logic                        clear_req,
  output logic                        clear_busy,
  sid_write_scheduler_if.slave        io
);

  localparam logic [SID_ADDR_W-1:0] LAST_ADDR = SID_ADDR_W'(NUM_REGS - 1);

  logic                  bus_full;
  logic [SID_ADDR_W-1:0] bus_addr_q;
  logic [SID_DATA_W-1:0] bus_data_q;
  logic                  overrun_q;

  clr_state_e            clr_state;
  clr_state_e            clr_state_nxt;
  logic [SID_ADDR_W-1:0] clr_cnt;

  sid_wr_t               cmd_in;
  sid_wr_t               cmd_head;
  logic                  cmd_head_vld;

  logic                  grant_bus;
  logic                  grant_clr;
  logic                  grant_cmd;

  assign cmd_in = '{addr: io.cmd_addr, data: io.cmd_data};

  sid_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .in_vld  (io.cmd_valid),
    .in_rdy  (io.cmd_ready),
    .in_dat  (cmd_in),
    .out_vld (cmd_head_vld),
    .out_rdy (grant_cmd),
    .out_dat (cmd_head)
  );

  // Fixed priority on each tick: bus slot, then clear sweep, then cmd head
  always_comb begin
    grant_bus = clk_en & bus_full;
    grant_clr = clk_en & ~bus_full & clear_busy;
    grant_cmd = clk_en & ~bus_full & ~clear_busy & cmd_head_vld;
  end

  // Single-entry bus slot; a fresh write overwrites a pending one that did not issue
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      bus_full   <= 1'b0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= io.bus_valid & bus_full & ~grant_bus;
      if (io.bus_valid) begin
        bus_full   <= 1'b1;
        bus_addr_q <= io.bus_addr;
        bus_data_q <= io.bus_data;
      end else if (grant_bus) begin
        bus_full <= 1'b0;
      end
    end
  end

  assign io.bus_overrun = overrun_q;

  // Clear FSM state register
  always_ff @(posedge sys_clk) begin
    if (!rst_n) clr_state <= CLR_IDLE;
    else        clr_state <= clr_state_nxt;
  end

  // Clear FSM next state; a new request restarts the sweep from address 0
  always_comb begin
    clr_state_nxt = clr_state;
    case (clr_state)
      CLR_IDLE: begin
        if (clear_req) clr_state_nxt = CLR_SWEEP;
      end
      CLR_SWEEP: begin
        if (clear_req)                                clr_state_nxt = CLR_SWEEP;
        else if (grant_clr && (clr_cnt == LAST_ADDR)) clr_state_nxt = CLR_IDLE;
      end
      default: clr_state_nxt = CLR_IDLE;
    endcase
  end

  // Clear FSM outputs
  always_comb begin
    clear_busy = (clr_state == CLR_SWEEP);
  end

  // Sweep address counter; only advances when the clear actually wins a tick
  always_ff @(posedge sys_clk) begin
    if (!rst_n)         clr_cnt <= '0;
    else if (clear_req) clr_cnt <= '0;
    else if (grant_clr) clr_cnt <= clr_cnt + SID_ADDR_W'(1);
  end

  // Registered SID port; addr/data hold between strobes
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      io.sid_wr     <= 1'b0;
      io.sid_addr   <= '0;
      io.sid_data   <= '0;
      io.sid_wr_src <= SRC_NONE;
    end else begin
      io.sid_wr <= grant_bus | grant_clr | grant_cmd;
      if (grant_bus) begin
        io.sid_addr   <= bus_addr_q;
        io.sid_data   <= bus_data_q;
        io.sid_wr_src <= SRC_BUS;
      end else if (grant_clr) begin
        io.sid_addr   <= clr_cnt;
        io.sid_data   <= '0;
        io.sid_wr_src <= SRC_CLEAR;
      end else if (grant_cmd) begin
        io.sid_addr   <= cmd_head.addr;
        io.sid_data   <= cmd_head.data;
        io.sid_wr_src <= SRC_CMD;
      end else begin
        io.sid_wr_src <= SRC_NONE;
      end
    end
  end

endmodule

// File: tb/tb_sid_write_scheduler.sv
// Bench for sid_write_scheduler: directed scenarios then random traffic against a queue model.
// Latency: model predicts the registered outputs visible after each sys_clk edge.
// Backpressure: cmd pushes only counted when the observed cmd_ready was high.
module tb_sid_write_scheduler;
  import sid_bus_pkg::*;

  localparam int DEPTH = 4;
  localparam int NREGS = 25;
  localparam int PER   = 8;

  logic sys_clk   = 1'b0;
  logic rst_n     = 1'b0;
  logic clk_en    = 1'b0;
  logic clear_req = 1'b0;
  logic clear_busy;

  sid_write_scheduler_if dif();

  sid_write_scheduler #(.FIFO_DEPTH(DEPTH), .NUM_REGS(NREGS)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .io         (dif)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending bus write, cmd queue, list position of the clear sweep
  bit          m_bus_pend = 0;
  logic [4:0]  m_bus_a = '0;
  logic [7:0]  m_bus_d = '0;
  logic [12:0] m_q[$];
  bit          m_clr = 0;
  int          m_clr_next = 0;

  logic       e_wr = 0, e_ovr = 0, e_rdy = 0, e_busy = 0;
  logic [4:0] e_addr = '0;
  logic [7:0] e_data = '0;
  logic [1:0] e_src = '0;

  int div = 0;
  bit en_on = 1;
  int ticks = 0, wr_cnt = 0, ovr_cnt = 0, clr_wr_cnt = 0, busy_ticks = 0;
  logic [4:0] last_a = '0;
  logic [7:0] last_d = '0;
  logic [1:0] last_src = '0;

  task automatic model_edge();
    bit push_ok;
    logic [12:0] w;
    if (!rst_n) begin
      m_bus_pend = 0; m_q.delete(); m_clr = 0; m_clr_next = 0;
      e_wr = 0; e_src = 0; e_addr = 0; e_data = 0; e_ovr = 0; e_rdy = 0; e_busy = 0;
      return;
    end
    push_ok = dif.cmd_valid && e_rdy;
    e_wr = 0;
    e_src = 2'd0;
    if (clk_en) begin
      if (m_bus_pend) begin
        e_wr = 1; e_src = 2'd1; e_addr = m_bus_a; e_data = m_bus_d;
        m_bus_pend = 0;
      end else if (m_clr) begin
        e_wr = 1; e_src = 2'd2; e_addr = 5'(m_clr_next); e_data = 8'h00;
        m_clr_next++;
        if (m_clr_next == NREGS) m_clr = 0;
      end else if (m_q.size() > 0) begin
        w = m_q.pop_front();
        e_wr = 1; e_src = 2'd3; e_addr = w[12:8]; e_data = w[7:0];
      end
    end
    e_ovr = dif.bus_valid && m_bus_pend;
    if (dif.bus_valid) begin
      m_bus_pend = 1; m_bus_a = dif.bus_addr; m_bus_d = dif.bus_data;
    end
    if (clear_req) begin
      m_clr = 1; m_clr_next = 0;
    end
    if (push_ok) m_q.push_back({dif.cmd_addr, dif.cmd_data});
    e_rdy  = (m_q.size() < DEPTH);
    e_busy = m_clr;
  endtask

  task automatic step();
    clk_en = en_on && (div == PER - 1);
    div = (div + 1) % PER;
    if (clk_en) ticks++;
    if (clk_en && clear_busy) busy_ticks++;
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    check_eq("sid_wr",      dif.sid_wr,      e_wr);
    check_eq("sid_wr_src",  dif.sid_wr_src,  e_src);
    check_eq("sid_addr",    dif.sid_addr,    e_addr);
    check_eq("sid_data",    dif.sid_data,    e_data);
    check_eq("bus_overrun", dif.bus_overrun, e_ovr);
    check_eq("cmd_ready",   dif.cmd_ready,   e_rdy);
    check_eq("clear_busy",  clear_busy,      e_busy);
    if (dif.sid_wr) begin
      wr_cnt++;
      last_a = dif.sid_addr; last_d = dif.sid_data; last_src = dif.sid_wr_src;
      if (dif.sid_wr_src == 2'd2) clr_wr_cnt++;
    end
    if (dif.bus_overrun) ovr_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_div(input int d);
    for (int k = 0; k < PER && div != d; k++) step();
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    dif.bus_valid = 1; dif.bus_addr = a; dif.bus_data = d;
    step();
    dif.bus_valid = 0;
  endtask

  task automatic cmd_push(input logic [4:0] a, input logic [7:0] d);
    dif.cmd_valid = 1; dif.cmd_addr = a; dif.cmd_data = d;
    step();
    dif.cmd_valid = 0;
  endtask

  initial begin
    int w0, o0, c0, t0, b0;
    bit accepted, injected;
    dif.bus_valid = 0; dif.bus_addr = '0; dif.bus_data = '0;
    dif.cmd_valid = 0; dif.cmd_addr = '0; dif.cmd_data = '0;

    // Reset, then three idle ticks
    rst_n = 0;
    run(3);
    rst_n = 1;
    w0 = wr_cnt;
    step();
    check_eq("rdy_after_rst", dif.cmd_ready, 1);
    run(3 * PER);
    check_eq("idle_no_wr", wr_cnt - w0, 0);

    // Single bus write mid-period
    wait_div(3);
    w0 = wr_cnt;
    bus_write(5'h18, 8'h0F);
    run(2 * PER);
    check_eq("bus1_cnt", wr_cnt - w0, 1);
    check_eq("bus1_addr", last_a, 5'h18);
    check_eq("bus1_data", last_d, 8'h0F);
    check_eq("bus1_src", last_src, 2'd1);

    // Two bus writes in one period: overrun, only the second issues
    wait_div(0);
    w0 = wr_cnt; o0 = ovr_cnt;
    bus_write(5'h00, 8'h11);
    step();
    bus_write(5'h01, 8'h22);
    run(2 * PER);
    check_eq("ovr_cnt", ovr_cnt - o0, 1);
    check_eq("ovr_wr_cnt", wr_cnt - w0, 1);
    check_eq("ovr_addr", last_a, 5'h01);
    check_eq("ovr_data", last_d, 8'h22);

    // Fill the cmd FIFO with ticks gated off; the fifth waits for space
    en_on = 0;
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) cmd_push(5'(i), 8'hA0 + 8'(i));
    dif.cmd_valid = 1; dif.cmd_addr = 5'd4; dif.cmd_data = 8'hA4;
    check_eq("cmd_full_rdy", dif.cmd_ready, 0);
    en_on = 1;
    accepted = 0;
    for (int k = 0; k < 8 * PER && !accepted; k++) begin
      if (dif.cmd_ready) accepted = 1;
      step();
    end
    dif.cmd_valid = 0;
    check_eq("cmd5_accepted", accepted, 1);
    run(6 * PER);
    check_eq("cmd_wr_cnt", wr_cnt - w0, 5);
    check_eq("cmd_last_addr", last_a, 5'd4);
    check_eq("cmd_last_data", last_d, 8'hA4);
    check_eq("cmd_last_src", last_src, 2'd3);

    // Clear sweep with two queued cmds and a bus write winning the third tick
    wait_div(0);
    w0 = wr_cnt;
    cmd_push(5'd5, 8'h55);
    cmd_push(5'd6, 8'h66);
    clear_req = 1;
    step();
    clear_req = 0;
    t0 = ticks; b0 = busy_ticks; c0 = clr_wr_cnt;
    injected = 0;
    for (int k = 0; k < 32 * PER; k++) begin
      if (!injected && (ticks - t0 == 2) && div == 2) begin
        injected = 1;
        bus_write(5'h12, 8'h77);
      end else begin
        step();
      end
    end
    check_eq("clr_busy_ticks", busy_ticks - b0, 26);
    check_eq("clr_wr_cnt", clr_wr_cnt - c0, 25);
    check_eq("clr_total_wr", wr_cnt - w0, 28);
    check_eq("clr_last_addr", last_a, 5'd6);
    check_eq("clr_last_data", last_d, 8'h66);

    // Reset in the middle of a sweep with two cmds queued
    clear_req = 1;
    step();
    clear_req = 0;
    c0 = clr_wr_cnt;
    cmd_push(5'd7, 8'h77);
    cmd_push(5'd8, 8'h88);
    for (int k = 0; k < 20 * PER && (clr_wr_cnt - c0) < 10; k++) step();
    check_eq("sweep_reached_10", clr_wr_cnt - c0, 10);
    rst_n = 0;
    run(2);
    rst_n = 1;
    w0 = wr_cnt;
    run(4 * PER);
    check_eq("post_rst_no_wr", wr_cnt - w0, 0);
    check_eq("post_rst_busy", clear_busy, 0);
    check_eq("post_rst_rdy", dif.cmd_ready, 1);

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      rst_n         = ($urandom_range(0, 999) != 0);
      dif.bus_valid = ($urandom_range(0, 9) == 0);
      dif.bus_addr  = 5'($urandom_range(0, 31));
      dif.bus_data  = 8'($urandom_range(0, 255));
      dif.cmd_valid = ($urandom_range(0, 2) == 0);
      dif.cmd_addr  = 5'($urandom_range(0, 31));
      dif.cmd_data  = 8'($urandom_range(0, 255));
      clear_req     = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_n = 1; dif.bus_valid = 0; dif.cmd_valid = 0; clear_req = 0;
    run(40 * PER);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
